rvc_asap_cr_bank: RTL and testbench

Parametrised control-register bank for the rvc_asap core's CR memory region. Generalises the fixed CR set (7-segment displays, LEDs, buttons, switches, VGA cursor) to configurable counts and widths. Adds input synchronisation, per-button debounce, sticky rising-edge capture with an interrupt mask, and per-byte writes. Sits behind the data-memory decoder on the CR region and drives board I/O and the VGA cursor.

---
 rtl/rvc_asap_cr_bank_if.sv | 22 ++
 rtl/rvc_asap_cr_bank.sv | 230 +++++++++++++++++++++++
 tb/tb_rvc_asap_cr_bank.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvc_asap_cr_bank_if.sv
// Control-register bus between the data-memory decoder and the CR bank.
// The decoder is the master. The bank is the slave and returns registered read data.
`timescale 1ns/1ps

interface rvc_asap_cr_bank_if;
    logic [15:0] CrAddr;
    logic        CrWrEn;
    logic        CrRdEn;
    logic [3:0]  CrByteEn;
    logic [31:0] CrWrData;
    logic [31:0] CrRdData;

    modport master (
        output CrAddr, CrWrEn, CrRdEn, CrByteEn, CrWrData,
        input  CrRdData
    );

    modport slave (
        input  CrAddr, CrWrEn, CrRdEn, CrByteEn, CrWrData,
        output CrRdData
    );
endinterface

// File: rtl/rvc_asap_cr_bank.sv
// Parametrised control-register bank for the rvc_asap CR region.
// It holds the 7-segment, LED and VGA-cursor registers and synchronises the raw buttons and switches.
// Each button is debounced, and rising edges of the debounced level are captured into a sticky,
// maskable interrupt register that software clears by writing 1.
`timescale 1ns/1ps

module rvc_asap_cr_bank #(
    parameter logic [15:0] CR_BASE   = 16'h2000,
    parameter int          N_SEG7    = 6,
    parameter int          LED_W     = 10,
    parameter int          SW_W      = 10,
    parameter int          N_BTN     = 2,
    parameter int          DB_CYCLES = 50000
) (
    input  logic                  Clock,
    input  logic                  Rst_N,
    rvc_asap_cr_bank_if.slave     cr,
    input  logic [N_BTN-1:0]      Button,
    input  logic [SW_W-1:0]       Switch,
    output logic [8*N_SEG7-1:0]   Seg7,
    output logic [LED_W-1:0]      Led,
    output logic [31:0]           CursorH,
    output logic [31:0]           CursorV,
    output logic                  BtnIrq
);

    localparam int             CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

    // Word offsets (byte offset >> 2) of the fixed registers
    localparam logic [9:0] W_LED     = 10'h010;
    localparam logic [9:0] W_BTN     = 10'h011;
    localparam logic [9:0] W_SW      = 10'h012;
    localparam logic [9:0] W_CURH    = 10'h013;
    localparam logic [9:0] W_CURV    = 10'h014;
    localparam logic [9:0] W_EDGE    = 10'h015;
    localparam logic [9:0] W_EDGE_EN = 10'h016;

    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } db_state_e;

    // Register state
    logic [7:0]       seg7_q [N_SEG7];
    logic [LED_W-1:0] led_q;
    logic [31:0]      curh_q;
    logic [31:0]      curv_q;
    logic [N_BTN-1:0] edge_q;
    logic [N_BTN-1:0] edge_d;
    logic [N_BTN-1:0] edge_en_q;
    logic [31:0]      rd_data_q;

    // Input synchronisers and debounce state
    logic [N_BTN-1:0] btn_s1_q;
    logic [N_BTN-1:0] btn_s2_q;
    logic [SW_W-1:0]  sw_s1_q;
    logic [SW_W-1:0]  sw_s2_q;
    db_state_e        db_state_q [N_BTN];
    logic [CW-1:0]    db_cnt_q   [N_BTN];

    // Decode
    logic             region_hit;
    logic [9:0]       word;
    logic             wr_en;
    logic             rd_en;
    logic [31:0]      wmask;
    logic [N_BTN-1:0] edge_clr;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] db_flip;
    logic [N_BTN-1:0] db_rise;
    logic [31:0]      rd_mux;
    logic             unused_addr_lsbs;

    assign region_hit       = (cr.CrAddr[15:12] == CR_BASE[15:12]);
    assign word             = cr.CrAddr[11:2];
    assign wr_en            = cr.CrWrEn & region_hit;
    assign rd_en            = cr.CrRdEn & region_hit;
    assign unused_addr_lsbs = ^cr.CrAddr[1:0];
    assign wmask            = {{8{cr.CrByteEn[3]}}, {8{cr.CrByteEn[2]}},
                               {8{cr.CrByteEn[1]}}, {8{cr.CrByteEn[0]}}};

    // W1C clear mask: only bits written as 1 in an enabled lane clear EDGE
    assign edge_clr = (wr_en && word == W_EDGE) ? (cr.CrWrData[N_BTN-1:0] & wmask[N_BTN-1:0])
                                                : '0;

    // Software-writable registers with per-byte masking; bits above a field's width are dropped
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            // NOTE: the 7-segment array is reset element by element so the displays come up blank;
            // this forces flops rather than a RAM, which is fine at a handful of bytes.
            for (int i = 0; i < N_SEG7; i++) seg7_q[i] <= '0;
            led_q     <= '0;
            curh_q    <= '0;
            curv_q    <= '0;
            edge_en_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_SEG7; i++) begin
                if (word == 10'(i) && cr.CrByteEn[0]) seg7_q[i] <= cr.CrWrData[7:0];
            end
            case (word)
                W_LED:     led_q     <= (led_q & ~wmask[LED_W-1:0])
                                      | (cr.CrWrData[LED_W-1:0] & wmask[LED_W-1:0]);
                W_CURH:    curh_q    <= (curh_q & ~wmask) | (cr.CrWrData & wmask);
                W_CURV:    curv_q    <= (curv_q & ~wmask) | (cr.CrWrData & wmask);
                W_EDGE_EN: edge_en_q <= (edge_en_q & ~wmask[N_BTN-1:0])
                                      | (cr.CrWrData[N_BTN-1:0] & wmask[N_BTN-1:0]);
                default:   ;
            endcase
        end
    end

    // Two-flop synchronisers on every raw button and switch bit
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= Button;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= Switch;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Debounce flip condition: the input has differed for DB_CYCLES consecutive clocks
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves a bit unassigned
        // and no latch is inferred.
        btn_level = '0;
        db_flip   = '0;
        db_rise   = '0;
        for (int b = 0; b < N_BTN; b++) begin
            btn_level[b] = (db_state_q[b] == STABLE_HI);
            db_flip[b]   = (btn_s2_q[b] != btn_level[b]) && (db_cnt_q[b] == DB_LAST);
            db_rise[b]   = db_flip[b] & ~btn_level[b];
        end
    end

    // Per-button debounce FSM: the counter runs while the input disagrees and clears otherwise
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) begin
            for (int b = 0; b < N_BTN; b++) begin
                db_state_q[b] <= STABLE_LO;
                db_cnt_q[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < N_BTN; b++) begin
                case (db_state_q[b])
                    STABLE_LO: begin
                        if (!btn_s2_q[b]) begin
                            db_cnt_q[b] <= '0;
                        end else if (db_flip[b]) begin
                            db_state_q[b] <= STABLE_HI;
                            db_cnt_q[b]   <= '0;
                        end else begin
                            // NOTE: non-blocking assignments throughout clocked logic, so every flop
                            // samples pre-edge values regardless of statement order.
                            db_cnt_q[b] <= db_cnt_q[b] + CW'(1);
                        end
                    end
                    STABLE_HI: begin
                        if (btn_s2_q[b]) begin
                            db_cnt_q[b] <= '0;
                        end else if (db_flip[b]) begin
                            db_state_q[b] <= STABLE_LO;
                            db_cnt_q[b]   <= '0;
                        end else begin
                            db_cnt_q[b] <= db_cnt_q[b] + CW'(1);
                        end
                    end
                    default: begin
                        db_state_q[b] <= STABLE_LO;
                        db_cnt_q[b]   <= '0;
                    end
                endcase
            end
        end
    end

    // Sticky edge capture: a new rise wins over a W1C clear in the same cycle
    assign edge_d = (edge_q & ~edge_clr) | db_rise;

    // EDGE register
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N) edge_q <= '0;
        else        edge_q <= edge_d;
    end

    // Read mux from current register values, so a same-cycle write is not yet visible
    always_comb begin
        rd_mux = '0;
        if (region_hit) begin
            for (int i = 0; i < N_SEG7; i++) begin
                if (word == 10'(i)) rd_mux = 32'(seg7_q[i]);
            end
            case (word)
                W_LED:     rd_mux = 32'(led_q);
                W_BTN:     rd_mux = 32'(btn_level);
                W_SW:      rd_mux = 32'(sw_s2_q);
                W_CURH:    rd_mux = curh_q;
                W_CURV:    rd_mux = curv_q;
                W_EDGE:    rd_mux = 32'(edge_q);
                W_EDGE_EN: rd_mux = 32'(edge_en_q);
                default:   ;
            endcase
        end
    end

    // Registered read data, held until the next read strobe
    always_ff @(posedge Clock or negedge Rst_N) begin
        if (!Rst_N)     rd_data_q <= '0;
        else if (rd_en) rd_data_q <= rd_mux;
    end

    // Flatten the display bytes onto the Seg7 bus
    always_comb begin
        Seg7 = '0;
        for (int i = 0; i < N_SEG7; i++) Seg7[8*i +: 8] = seg7_q[i];
    end

    assign Led         = led_q;
    assign CursorH     = curh_q;
    assign CursorV     = curv_q;
    assign BtnIrq      = |(edge_q & edge_en_q);
    assign cr.CrRdData = rd_data_q;

endmodule

// File: tb/tb_rvc_asap_cr_bank.sv
// Directed self-checking bench for rvc_asap_cr_bank. DB_CYCLES is set to 4 so debounce timing is short.
`timescale 1ns/1ps

module tb_rvc_asap_cr_bank;

    localparam int N_SEG7 = 6;
    localparam int LED_W  = 10;
    localparam int SW_W   = 10;
    localparam int N_BTN  = 2;

    logic                clk;
    logic                rst_n;
    logic [N_BTN-1:0]    button;
    logic [SW_W-1:0]     switch_in;
    logic [8*N_SEG7-1:0] seg7;
    logic [LED_W-1:0]    led;
    logic [31:0]         cursor_h;
    logic [31:0]         cursor_v;
    logic                btn_irq;

    int checks   = 0;
    int failures = 0;

    rvc_asap_cr_bank_if bus ();

    rvc_asap_cr_bank #(
        .CR_BASE   (16'h2000),
        .N_SEG7    (N_SEG7),
        .LED_W     (LED_W),
        .SW_W      (SW_W),
        .N_BTN     (N_BTN),
        .DB_CYCLES (4)
    ) dut (
        .Clock   (clk),
        .Rst_N   (rst_n),
        .cr      (bus),
        .Button  (button),
        .Switch  (switch_in),
        .Seg7    (seg7),
        .Led     (led),
        .CursorH (cursor_h),
        .CursorV (cursor_v),
        .BtnIrq  (btn_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000ns");
        $fatal(1, "watchdog");
    end

    task automatic cr_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.CrAddr   = a;
        bus.CrWrData = d;
        bus.CrByteEn = be;
        bus.CrWrEn   = 1'b1;
        @(posedge clk);
        #1;
        bus.CrWrEn   = 1'b0;
        bus.CrByteEn = 4'b0000;
    endtask

    task automatic cr_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.CrAddr = a;
        bus.CrRdEn = 1'b1;
        @(posedge clk);
        #1;
        d = bus.CrRdData;
        bus.CrRdEn = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        checks++;
        if ({seg7, led, cursor_h, cursor_v, btn_irq} !== '0) begin
            failures++;
            $display("FAIL reset_initial: outputs=%h required all zero", {seg7, led, cursor_h, cursor_v, btn_irq});
        end
        checks++;
        if (bus.CrRdData !== 32'h0) begin
            failures++;
            $display("FAIL reset_rddata: got %h required 00000000", bus.CrRdData);
        end
        cr_write(16'h2040, 32'h0000_03FF, 4'b1111);
        cr_write(16'h204C, 32'h1234_5678, 4'b1111);
        checks++;
        if (led !== 10'h3FF) begin
            failures++;
            $display("FAIL reset_led_pre: got %h required 3ff", led);
        end
        cr_read(16'h2040, rd);
        checks++;
        if (rd !== 32'h0000_03FF) begin
            failures++;
            $display("FAIL reset_led_read: got %h required 000003ff", rd);
        end
        // Assert reset mid-cycle, away from any clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({seg7, led, cursor_h, cursor_v, btn_irq} !== '0) begin
            failures++;
            $display("FAIL reset_async_outputs: led=%h cursor_h=%h required zero", led, cursor_h);
        end
        checks++;
        if (bus.CrRdData !== 32'h0) begin
            failures++;
            $display("FAIL reset_async_rddata: got %h required 00000000", bus.CrRdData);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        cr_write(16'h204C, 32'hAABB_CCDD, 4'b0101);
        checks++;
        if (cursor_h !== 32'h00BB_00DD) begin
            failures++;
            $display("FAIL be_cursor_h: got %h required 00bb00dd", cursor_h);
        end
        cr_write(16'h2050, 32'hCAFE_F00D, 4'b1100);
        checks++;
        if (cursor_v !== 32'hCAFE_0000) begin
            failures++;
            $display("FAIL be_cursor_v: got %h required cafe0000", cursor_v);
        end
        cr_write(16'h2040, 32'hFFFF_FFFF, 4'b1111);
        checks++;
        if (led !== 10'h3FF) begin
            failures++;
            $display("FAIL be_led_trunc: got %h required 3ff", led);
        end
        cr_read(16'h2040, rd);
        checks++;
        if (rd !== 32'h0000_03FF) begin
            failures++;
            $display("FAIL be_led_read: got %h required 000003ff", rd);
        end
        cr_write(16'h2040, 32'h0000_0000, 4'b0010);
        checks++;
        if (led !== 10'h0FF) begin
            failures++;
            $display("FAIL be_led_lane1: got %h required 0ff", led);
        end
    endtask

    task automatic test_map_boundaries();
        logic [31:0] rd;
        cr_write(16'h2014, 32'h0000_005A, 4'b0001);
        checks++;
        if (seg7 !== 48'h5A00_0000_0000) begin
            failures++;
            $display("FAIL map_seg7_5: got %h required 5a0000000000", seg7);
        end
        cr_write(16'h2000, 32'h0000_00C3, 4'b0001);
        checks++;
        if (seg7 !== 48'h5A00_0000_00C3) begin
            failures++;
            $display("FAIL map_seg7_0: got %h required 5a00000000c3", seg7);
        end
        cr_write(16'h2018, 32'hFFFF_FFFF, 4'b1111);
        checks++;
        if (seg7 !== 48'h5A00_0000_00C3 || led !== 10'h0FF) begin
            failures++;
            $display("FAIL map_unmapped_wr: seg7=%h led=%h required 5a00000000c3 0ff", seg7, led);
        end
        cr_read(16'h2018, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL map_unmapped_rd: got %h required 00000000", rd);
        end
        cr_write(16'h3040, 32'h0000_0000, 4'b1111);
        checks++;
        if (led !== 10'h0FF) begin
            failures++;
            $display("FAIL map_out_region_wr: led=%h required 0ff", led);
        end
        cr_read(16'h3040, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL map_out_region_rd: got %h required 00000000", rd);
        end
        cr_read(16'h2014, rd);
        checks++;
        if (rd !== 32'h0000_005A) begin
            failures++;
            $display("FAIL map_seg7_5_rd: got %h required 0000005a", rd);
        end
    endtask

    task automatic test_switch_and_rdw();
        logic [31:0] rd;
        @(negedge clk);
        switch_in = 10'h155;
        @(posedge clk);
        cr_read(16'h2048, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL sw_clock2: got %h required 00000000", rd);
        end
        cr_read(16'h2048, rd);
        checks++;
        if (rd !== 32'h0000_0155) begin
            failures++;
            $display("FAIL sw_clock3: got %h required 00000155", rd);
        end
        // Same-cycle read and write of LED returns the pre-write value
        @(negedge clk);
        bus.CrAddr   = 16'h2040;
        bus.CrWrData = 32'h0000_0123;
        bus.CrByteEn = 4'b1111;
        bus.CrWrEn   = 1'b1;
        bus.CrRdEn   = 1'b1;
        @(posedge clk);
        #1;
        bus.CrWrEn   = 1'b0;
        bus.CrRdEn   = 1'b0;
        bus.CrByteEn = 4'b0000;
        checks++;
        if (bus.CrRdData !== 32'h0000_00FF) begin
            failures++;
            $display("FAIL rdw_old_value: got %h required 000000ff", bus.CrRdData);
        end
        checks++;
        if (led !== 10'h123) begin
            failures++;
            $display("FAIL rdw_new_led: got %h required 123", led);
        end
    endtask

    task automatic test_debounce();
        logic [31:0] rd;
        bit irq_seen;
        cr_write(16'h2058, 32'h0000_0001, 4'b1111);
        // Three-clock glitch must be rejected
        @(negedge clk);
        button[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        button[0] = 1'b0;
        irq_seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (btn_irq !== 1'b0) irq_seen = 1'b1;
        end
        checks++;
        if (irq_seen) begin
            failures++;
            $display("FAIL db_glitch_irq: BtnIrq rose, required 0");
        end
        cr_read(16'h2044, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL db_glitch_btn: got %h required 00000000", rd);
        end
        cr_read(16'h2054, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL db_glitch_edge: got %h required 00000000", rd);
        end
        // Held high: debounced level rises exactly 6 clocks after the raw rise
        @(negedge clk);
        button[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (btn_irq !== 1'b0) begin
            failures++;
            $display("FAIL db_hold_clock5: BtnIrq=%b required 0", btn_irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (btn_irq !== 1'b1) begin
            failures++;
            $display("FAIL db_hold_clock6: BtnIrq=%b required 1", btn_irq);
        end
        cr_read(16'h2044, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            failures++;
            $display("FAIL db_hold_btn: got %h required 00000001", rd);
        end
        cr_read(16'h2054, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            failures++;
            $display("FAIL db_hold_edge: got %h required 00000001", rd);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] rd;
        // A 1 in a disabled lane must not clear
        cr_write(16'h2054, 32'h0000_0001, 4'b1110);
        checks++;
        if (btn_irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_lane_off: BtnIrq=%b required 1", btn_irq);
        end
        cr_write(16'h2054, 32'h0000_0001, 4'b0001);
        checks++;
        if (btn_irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_clear_irq: BtnIrq=%b required 0", btn_irq);
        end
        cr_read(16'h2054, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL w1c_clear_edge: got %h required 00000000", rd);
        end
        // Release and let the debounced level fall
        @(negedge clk);
        button[0] = 1'b0;
        repeat (10) @(posedge clk);
        cr_read(16'h2044, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL w1c_release_btn: got %h required 00000000", rd);
        end
        // New rise lands on the same edge as a W1C: set wins
        @(negedge clk);
        button[0] = 1'b1;
        repeat (5) @(posedge clk);
        cr_write(16'h2054, 32'h0000_0001, 4'b0001);
        checks++;
        if (btn_irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_collision_irq: BtnIrq=%b required 1", btn_irq);
        end
        cr_read(16'h2054, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin
            failures++;
            $display("FAIL w1c_collision_edge: got %h required 00000001", rd);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        button       = '0;
        switch_in    = '0;
        bus.CrAddr   = 16'h0;
        bus.CrWrEn   = 1'b0;
        bus.CrRdEn   = 1'b0;
        bus.CrByteEn = 4'b0;
        bus.CrWrData = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_byte_enable();
        test_map_boundaries();
        test_switch_and_rdw();
        test_debounce();
        test_w1c();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
